// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory-stage load/store unit and the data memory.
// The unit drives the request fields; the memory answers with Ready/RValid/RData.
interface memory_access_unit_if;
    logic        DMEM_Req;
    logic        DMEM_We;
    logic [31:0] DMEM_Addr;
    logic [31:0] DMEM_WData;
    logic [3:0]  DMEM_Strb;
    logic        DMEM_Ready;
    logic        DMEM_RValid;
    logic [31:0] DMEM_RData;

    modport master (
        output DMEM_Req, DMEM_We, DMEM_Addr, DMEM_WData, DMEM_Strb,
        input  DMEM_Ready, DMEM_RValid, DMEM_RData
    );

    modport slave (
        input  DMEM_Req, DMEM_We, DMEM_Addr, DMEM_WData, DMEM_Strb,
        output DMEM_Ready, DMEM_RValid, DMEM_RData
    );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: runs one valid/ready bus transaction per access,
// stalls the pipeline meanwhile, and returns extended load data or a fault/timeout flag.
module memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        Valid_M,
    input  logic                        MEM_W_En_M,
    input  logic [1:0]                  Result_Src_Sel_M,
    input  logic [2:0]                  MEM_Control_M,
    input  logic [31:0]                 ALU_Result_M,
    input  logic [31:0]                 Write_Data_M,
    memory_access_unit_if.master        dmem,
    output logic                        Stall_M,
    output logic [31:0]                 Read_Data_M,
    output logic                        Fault_M,
    output logic                        Bus_Err_M
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         strb_q, strb_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_store, is_load, access, fault, misalign, reserved, timeout;
    logic [3:0]         fmt_strb;
    logic [31:0]        fmt_wdata, load_ext;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    assign is_store = MEM_W_En_M;
    assign is_load  = (Result_Src_Sel_M == 2'b01);
    assign access   = Valid_M & (is_store | is_load);
    assign fault    = access & (reserved | misalign);

    always_comb begin
        misalign = 1'b0;
        reserved = 1'b0;
        case (MEM_Control_M)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = ALU_Result_M[0];
            3'b010:         misalign = (ALU_Result_M[1:0] != 2'b00);
            default:        reserved = 1'b1;
        endcase
    end

    always_comb begin
        fmt_strb  = 4'b1111;
        fmt_wdata = Write_Data_M;
        case (MEM_Control_M[1:0])
            2'b00: begin
                fmt_strb  = 4'b0001 << ALU_Result_M[1:0];
                fmt_wdata = {4{Write_Data_M[7:0]}};
            end
            2'b01: begin
                fmt_strb  = ALU_Result_M[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{Write_Data_M[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = dmem.DMEM_RData[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? dmem.DMEM_RData[31:16] : dmem.DMEM_RData[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'h0, ld_byte};
            3'b101:  load_ext = {16'h0, ld_half};
            default: load_ext = dmem.DMEM_RData;
        endcase
    end

    // >= rather than ==: a load accepted on the last REQ cycle gets exactly one WAIT cycle.
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !fault) begin
                    we_d     = is_store;
                    addr_d   = {ALU_Result_M[31:2], 2'b00};
                    wdata_d  = fmt_wdata;
                    strb_d   = is_store ? fmt_strb : 4'b0000;
                    funct3_d = MEM_Control_M;
                    off_d    = ALU_Result_M[1:0];
                    cnt_d    = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem.DMEM_Ready) begin
                    state_d = we_q ? StDone : StWait;
                end else if (timeout) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem.DMEM_RValid) begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end else if (timeout) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dmem.DMEM_Req   = (state_q == StReq);
    assign dmem.DMEM_We    = we_q;
    assign dmem.DMEM_Addr  = addr_q;
    assign dmem.DMEM_WData = wdata_q;
    assign dmem.DMEM_Strb  = strb_q;

    assign Stall_M     = ((state_q == StIdle) & access & ~fault) | (state_q == StReq) |
                         (state_q == StWait);
    assign Fault_M     = (state_q == StIdle) & fault;
    assign Read_Data_M = rdata_q;
    assign Bus_Err_M   = bus_err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed test-plan steps plus randomized accesses
// checked against an arithmetic reference model of formatting, extension and timing.
module tb_memory_access_unit;

    localparam int T = 4;

    logic        CLK;
    logic        RST_N;
    logic        Valid_M;
    logic        MEM_W_En_M;
    logic [1:0]  Result_Src_Sel_M;
    logic [2:0]  MEM_Control_M;
    logic [31:0] ALU_Result_M;
    logic [31:0] Write_Data_M;
    logic        Stall_M;
    logic [31:0] Read_Data_M;
    logic        Fault_M;
    logic        Bus_Err_M;

    memory_access_unit_if bus ();

    memory_access_unit #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .Valid_M          (Valid_M),
        .MEM_W_En_M       (MEM_W_En_M),
        .Result_Src_Sel_M (Result_Src_Sel_M),
        .MEM_Control_M    (MEM_Control_M),
        .ALU_Result_M     (ALU_Result_M),
        .Write_Data_M     (Write_Data_M),
        .dmem             (bus.master),
        .Stall_M          (Stall_M),
        .Read_Data_M      (Read_Data_M),
        .Fault_M          (Fault_M),
        .Bus_Err_M        (Bus_Err_M)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] rd_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic bit fault_ref(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (addr % 2) != 0;
            3'd2:       return (addr % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> ((addr % 4) * 8)) & 32'hFF;
        h = (word >> (((addr % 4) / 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] strb_ref(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 4'(1 << (addr % 4));
            3'd1:    return 4'(3 << (((addr % 4) / 2) * 2));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] wdata_ref(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One access from IDLE back to IDLE; rd/vd are the Ready/RValid delays in cycles.
    task automatic run_access(input bit st, input bit ld, input bit vld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rword, input int rd, input int vd);
        bit acc, flt, err, is_ld;
        int req_n, wait_n, avail;
        acc   = vld && (st || ld);
        flt   = acc && fault_ref(f3, addr);
        is_ld = ld && !st;

        @(negedge CLK);
        Valid_M          = vld;
        MEM_W_En_M       = st;
        Result_Src_Sel_M = ld ? 2'b01 : 2'b00;
        MEM_Control_M    = f3;
        ALU_Result_M     = addr;
        Write_Data_M     = wd;
        bus.DMEM_Ready   = 1'b1;
        bus.DMEM_RValid  = 1'b1;
        bus.DMEM_RData   = $urandom;
        #1;
        chk("idle_fault", 32'(Fault_M), 32'(flt));
        chk("idle_stall", 32'(Stall_M), 32'(acc && !flt));
        chk("idle_req", 32'(bus.DMEM_Req), 32'd0);
        chk("idle_rdata", Read_Data_M, rd_exp);

        if (!acc || flt) begin
            @(negedge CLK);
            Valid_M         = 1'b0;
            bus.DMEM_Ready  = 1'b0;
            bus.DMEM_RValid = 1'b0;
            #1;
            chk("skip_req", 32'(bus.DMEM_Req), 32'd0);
            chk("skip_fault_clear", 32'(Fault_M), 32'd0);
            chk("skip_stall", 32'(Stall_M), 32'd0);
            chk("skip_rdata", Read_Data_M, rd_exp);
            return;
        end

        req_n = (rd + 1 > T) ? T : rd + 1;
        err   = (rd + 1 > T);
        for (int k = 0; k < req_n; k++) begin
            @(negedge CLK);
            Valid_M         = 1'($urandom_range(0, 1));
            bus.DMEM_Ready  = (k == rd);
            bus.DMEM_RValid = 1'($urandom_range(0, 1));
            bus.DMEM_RData  = $urandom;
            #1;
            chk("req_req", 32'(bus.DMEM_Req), 32'd1);
            chk("req_stall", 32'(Stall_M), 32'd1);
            chk("req_addr", bus.DMEM_Addr, addr & 32'hFFFF_FFFC);
            chk("req_we", 32'(bus.DMEM_We), 32'(st));
            chk("req_buserr", 32'(Bus_Err_M), 32'd0);
            if (st) begin
                chk("req_strb", 32'(bus.DMEM_Strb), 32'(strb_ref(f3, addr)));
                chk("req_wdata", bus.DMEM_WData, wdata_ref(f3, wd));
            end
        end

        if (is_ld && !err) begin
            avail  = T - (rd + 1);
            if (avail < 1) avail = 1;
            wait_n = (vd + 1 > avail) ? avail : vd + 1;
            err    = (vd + 1 > avail);
            for (int j = 0; j < wait_n; j++) begin
                @(negedge CLK);
                bus.DMEM_Ready  = 1'($urandom_range(0, 1));
                bus.DMEM_RValid = (j == vd);
                bus.DMEM_RData  = (j == vd) ? rword : $urandom;
                #1;
                chk("wait_req", 32'(bus.DMEM_Req), 32'd0);
                chk("wait_stall", 32'(Stall_M), 32'd1);
            end
        end

        if (is_ld) rd_exp = err ? 32'd0 : load_ref(f3, addr, rword);

        @(negedge CLK);
        Valid_M         = 1'b0;
        bus.DMEM_Ready  = 1'b1;
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = $urandom;
        #1;
        chk("done_stall", 32'(Stall_M), 32'd0);
        chk("done_req", 32'(bus.DMEM_Req), 32'd0);
        chk("done_buserr", 32'(Bus_Err_M), 32'(err));
        chk("done_rdata", Read_Data_M, rd_exp);

        @(negedge CLK);
        bus.DMEM_Ready  = 1'b0;
        bus.DMEM_RValid = 1'b0;
        #1;
        chk("back_idle_buserr", 32'(Bus_Err_M), 32'd0);
        chk("back_idle_stall", 32'(Stall_M), 32'd0);
        chk("back_idle_req", 32'(bus.DMEM_Req), 32'd0);
        chk("back_idle_rdata", Read_Data_M, rd_exp);
    endtask

    initial begin
        RST_N            = 1'b0;
        Valid_M          = 1'b0;
        MEM_W_En_M       = 1'b0;
        Result_Src_Sel_M = 2'b00;
        MEM_Control_M    = 3'b000;
        ALU_Result_M     = '0;
        Write_Data_M     = '0;
        bus.DMEM_Ready   = 1'b0;
        bus.DMEM_RValid  = 1'b0;
        bus.DMEM_RData   = '0;

        @(negedge CLK);
        #1;
        chk("rst_req", 32'(bus.DMEM_Req), 32'd0);
        chk("rst_we", 32'(bus.DMEM_We), 32'd0);
        chk("rst_addr", bus.DMEM_Addr, 32'd0);
        chk("rst_wdata", bus.DMEM_WData, 32'd0);
        chk("rst_strb", 32'(bus.DMEM_Strb), 32'd0);
        chk("rst_rdata", Read_Data_M, 32'd0);
        chk("rst_buserr", 32'(Bus_Err_M), 32'd0);
        chk("rst_stall", 32'(Stall_M), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // LB sign-extend from lane 3, Ready immediate, RValid next cycle.
        run_access(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0);
        // SH to upper half.
        run_access(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 0);
        // LW with Ready on the last allowed cycle.
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, 0);
        // Misaligned LW and reserved funct3.
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0042, 32'h0, 32'h0, 0, 0);
        run_access(1'b0, 1'b1, 1'b1, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0, 0);
        // Ready never arrives: timeout abort zeroes the load result.
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'h5555_5555, 100, 0);
        // Store and load both decoded: store wins.
        run_access(1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 1, 0);
        // Bubble with load control bits: no access.
        run_access(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, w, r;
            logic [2:0]  f;
            bit          s;
            a = $urandom;
            w = $urandom;
            r = $urandom;
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (s) begin
                f = 3'($urandom_range(0, 3));
                if (f == 3'd3 && $urandom_range(0, 1) == 1) f = 3'd7;
            end else begin
                f = 3'($urandom_range(0, 7));
            end
            run_access(s, !s, 1'b1, f, a, w, r, $urandom_range(0, 4), $urandom_range(0, 3));
        end

        // LHU from the upper half of 0xFFFF8000.
        run_access(1'b0, 1'b1, 1'b1, 3'b101, 32'h0000_0102, 32'h0, 32'hFFFF_8000, 1, 1);

        // Reset asserted while waiting for read data.
        @(negedge CLK);
        Valid_M          = 1'b1;
        MEM_W_En_M       = 1'b0;
        Result_Src_Sel_M = 2'b01;
        MEM_Control_M    = 3'b010;
        ALU_Result_M     = 32'h0000_0080;
        bus.DMEM_Ready   = 1'b0;
        bus.DMEM_RValid  = 1'b0;
        #1;
        chk("rw_idle_stall", 32'(Stall_M), 32'd1);
        @(negedge CLK);
        bus.DMEM_Ready = 1'b1;
        #1;
        chk("rw_req", 32'(bus.DMEM_Req), 32'd1);
        @(negedge CLK);
        bus.DMEM_Ready = 1'b0;
        Valid_M        = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(Stall_M), 32'd1);
        RST_N  = 1'b0;
        rd_exp = 32'd0;
        #1;
        chk("rw_rst_req", 32'(bus.DMEM_Req), 32'd0);
        chk("rw_rst_stall", 32'(Stall_M), 32'd0);
        chk("rw_rst_rdata", Read_Data_M, 32'd0);
        @(negedge CLK);
        RST_N           = 1'b1;
        bus.DMEM_RValid = 1'b1;
        bus.DMEM_RData  = 32'h1234_5678;
        #1;
        chk("rw_post_stall", 32'(Stall_M), 32'd0);
        @(negedge CLK);
        bus.DMEM_RValid = 1'b0;
        #1;
        chk("rw_post_rdata", Read_Data_M, 32'd0);
        chk("rw_post_req", 32'(bus.DMEM_Req), 32'd0);

        // Normal operation after reset.
        run_access(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_7F00, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Memory-stage load/store unit directly downstream of the execute stage.
- Consumes the EX/MEM-registered ALU result (effective address), store data and memory control.
- Runs a valid/ready transaction on the data-memory bus and stalls the pipeline until the access completes.
- Returns sign- or zero-extended load data to writeback, and flags misaligned/reserved accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ or WAIT before the access is aborted.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- Valid_M  in  1  memory-stage instruction is valid (not a bubble).
- MEM_W_En_M  in  1  store instruction.
- Result_Src_Sel_M  in  2  2'b01 = load instruction.
- MEM_Control_M  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others reserved.
- ALU_Result_M  in  32  effective byte address.
- Write_Data_M  in  32  store source (rs2).
- DMEM_Req  out  1  bus request valid.
- DMEM_We  out  1  1 = write.
- DMEM_Addr  out  32  word address, bits [1:0] = 0.
- DMEM_WData  out  32  lane-replicated store data.
- DMEM_Strb  out  4  byte enables.
- DMEM_Ready  in  1  request accepted.
- DMEM_RValid  in  1  read data valid.
- DMEM_RData  in  32  read word.
- Stall_M  out  1  to hazard unit; freezes IF..MEM.
- Read_Data_M  out  32  extended load result.
- Fault_M  out  1  misaligned or reserved access; one cycle per offending instruction.
- Bus_Err_M  out  1  timeout abort; one-cycle pulse in DONE.

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - DMEM_Req, DMEM_We, DMEM_Strb, DMEM_Addr, DMEM_WData, Read_Data_M, Bus_Err_M and the counter all go to 0.
  - DMEM_Req drops immediately, including mid-transaction.
- Access decode:
  - access = Valid_M & (MEM_W_En_M | Result_Src_Sel_M==01).
  - If both a store and a load are decoded, the store wins.
- Fault detection (combinational, IDLE only):
  - Fault = access & (reserved funct3, or H/HU with addr[0]=1, or W with addr[1:0]!=0).
  - A faulting instruction gets no bus transaction and no stall; the pipeline advances.
  - Read_Data_M is unchanged.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on access & !fault, register the bus fields and go to REQ. Stall_M=1 this cycle.
  - REQ: DMEM_Req=1; fields are held stable until DMEM_Ready. On Req&Ready: a store goes to DONE, a load goes to WAIT.
  - WAIT: on DMEM_RValid, capture the extended data into Read_Data_M and go to DONE.
  - DONE: Stall_M=0 for exactly one cycle, then IDLE. The instruction leaves MEM at this edge.
- Stall_M = (IDLE & access & !fault) | REQ | WAIT.
- Minimum occupancy: 3 cycles for a store, 4 cycles for a load.
- DMEM_Ready is ignored outside REQ; DMEM_RValid is ignored outside WAIT.
- Store formatting:
  - B: Strb = 1<<addr[1:0]; WData = byte replicated x4.
  - H: Strb = 0011 if addr[1]=0, else 1100; WData = half replicated x2.
  - W: Strb = 1111.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - Read_Data_M holds its value until the next load completes.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: drop Req, go to DONE with Bus_Err_M=1.
  - A load that times out writes Read_Data_M = 0.
  - Ready or RValid arriving in the same cycle as the limit wins over the timeout.
- Valid_M falling while in REQ or WAIT is ignored: the access runs to completion.

Test Plan:
- LB, addr=0x1003, RData=0x80FF_FF7F, Ready immediate, RValid next cycle -> Read_Data_M=0xFFFF_FF80; Stall_M high 3 cycles, low in DONE.
- SH, addr=0x2002, data=0x1234_ABCD -> DMEM_Addr=0x2000, Strb=1100, WData=0xABCD_ABCD, We=1; DONE 2 cycles after IDLE.
- LW, addr=0x40, Ready delayed 3 cycles -> Req/Addr/We held stable all 3 cycles; single handshake; LHU on 0xFFFF8000 lane 1 -> 0x0000_FFFF.
- LW, addr=0x42 -> Fault_M=1 for 1 cycle, DMEM_Req never asserts, Stall_M=0; funct3=011 gives the same result.
- Ready never asserted, TIMEOUT_CYCLES=4 -> Req drops after 4 cycles, Bus_Err_M pulses 1 cycle, Read_Data_M=0, FSM returns to IDLE.
- RST_N low while in WAIT -> DMEM_Req=0 and Stall_M=0 immediately; RValid arriving after reset release is ignored; Read_Data_M=0.
